// File: rtl/btb.sv
// ---------------------------------------------------------------------------
// btb : fully associative branch target buffer
//
// Every entry holds a valid bit, a 30-bit tag (pc[31:2]), a 32-bit target and
// a 2-bit saturating direction counter.
//
// The IF lookup is purely combinational and reads only registered state.
// Branches resolved in EX update a matching entry. A taken branch that misses
// is allocated into the slot named by victim_index. ID-stage hits are sent to
// the replacement policy as recency refreshes.
//
// Ports
//   clk, resetn           clock (rising edge), async active-low reset
//   if_pc                 fetch PC to look up
//   hit, hit_index        lookup result and index of the matching entry
//   pred_taken            counter MSB of the matching entry (0 on miss)
//   pred_target           target of the matching entry (0 on miss)
//   id_valid, id_stall,
//   id_hit, id_hit_index  ID-stage instruction and its BTB hit info
//   ex_valid, ex_pc,
//   ex_taken, ex_target   resolved branch from EX
//   flush_all             invalidate every entry
//   victim_index          replacement candidate from the pseudo-LRU policy
//   replace_en            allocation happens this cycle
//   fresh_en,
//   fresh_line_index      recency refresh to the replacement policy
// ---------------------------------------------------------------------------
module btb #(
    parameter int WIDTH    = 4,
    parameter int LINE_NUM = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      if_pc,
    output logic             hit,
    output logic [WIDTH-1:0] hit_index,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             id_valid,
    input  logic             id_stall,
    input  logic             id_hit,
    input  logic [WIDTH-1:0] id_hit_index,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             flush_all,
    input  logic [WIDTH-1:0] victim_index,
    output logic             replace_en,
    output logic             fresh_en,
    output logic [WIDTH-1:0] fresh_line_index
);

    logic [LINE_NUM-1:0] valid_q, valid_d;
    logic [29:0]         tag_q    [LINE_NUM];
    logic [29:0]         tag_d    [LINE_NUM];
    logic [31:0]         target_q [LINE_NUM];
    logic [31:0]         target_d [LINE_NUM];
    logic [1:0]          cnt_q    [LINE_NUM];
    logic [1:0]          cnt_d    [LINE_NUM];

    logic [LINE_NUM-1:0] if_match;
    logic [LINE_NUM-1:0] ex_match;
    logic [WIDTH-1:0]    ex_index;
    logic                ex_hit;

    // The PC byte offset is not part of the tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    // Tags are unique among valid entries, so at most one match bit is set.
    // ORing the indices of the set bits therefore yields the matching index.
    always_comb begin
        if_match  = '0;
        ex_match  = '0;
        hit_index = '0;
        ex_index  = '0;
        for (int i = 0; i < LINE_NUM; i++) begin
            if_match[i] = valid_q[i] && (tag_q[i] == if_pc[31:2]);
            ex_match[i] = valid_q[i] && (tag_q[i] == ex_pc[31:2]);
            if (if_match[i]) hit_index = hit_index | WIDTH'(i);
            if (ex_match[i]) ex_index  = ex_index  | WIDTH'(i);
        end
        hit         = |if_match;
        ex_hit      = |ex_match;
        pred_taken  = hit && cnt_q[hit_index][1];
        pred_target = hit ? target_q[hit_index] : 32'h0;
    end

    // Gating with resetn keeps the policy strobes quiet while reset is held.
    // A flush suppresses both strobes because it also suppresses the write.
    assign replace_en       = resetn && !flush_all && ex_valid && ex_taken && !ex_hit;
    assign fresh_en         = resetn && !flush_all && id_valid && !id_stall && id_hit
                              && !replace_en;
    assign fresh_line_index = id_hit_index;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (flush_all) begin
            // Only the valid bits clear. Tag, target and counter are kept.
            valid_d = '0;
        end else if (ex_valid) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    if (cnt_q[ex_index] != 2'b11) cnt_d[ex_index] = cnt_q[ex_index] + 2'b01;
                    target_d[ex_index] = ex_target;
                end else begin
                    if (cnt_q[ex_index] != 2'b00) cnt_d[ex_index] = cnt_q[ex_index] - 2'b01;
                end
            end else if (ex_taken) begin
                valid_d[victim_index]  = 1'b1;
                tag_d[victim_index]    = ex_pc[31:2];
                target_d[victim_index] = ex_target;
                cnt_d[victim_index]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < LINE_NUM; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LINE_NUM; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_btb.sv
module tb_btb;
    localparam int W = 4;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   if_pc = '0;
    logic          hit;
    logic [W-1:0]  hit_index;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          id_valid = 1'b0, id_stall = 1'b0, id_hit = 1'b0;
    logic [W-1:0]  id_hit_index = '0;
    logic          ex_valid = 1'b0, ex_taken = 1'b0;
    logic [31:0]   ex_pc = '0, ex_target = '0;
    logic          flush_all = 1'b0;
    logic [W-1:0]  victim_index = '0;
    logic          replace_en, fresh_en;
    logic [W-1:0]  fresh_line_index;

    int checks = 0;
    int errors = 0;

    btb #(.WIDTH(W), .LINE_NUM(N)) dut (
        .clk(clk), .resetn(resetn), .if_pc(if_pc),
        .hit(hit), .hit_index(hit_index), .pred_taken(pred_taken),
        .pred_target(pred_target),
        .id_valid(id_valid), .id_stall(id_stall), .id_hit(id_hit),
        .id_hit_index(id_hit_index),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target),
        .flush_all(flush_all), .victim_index(victim_index),
        .replace_en(replace_en), .fresh_en(fresh_en),
        .fresh_line_index(fresh_line_index)
    );

    always #5 clk = ~clk;

    // Behavioural model: a table of entries searched by tag.
    logic        m_valid [N];
    logic [29:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];

    function automatic int find(input logic [31:0] pc);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == pc[31:2]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = 1;
            end
        end else if (flush_all) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        end else if (ex_valid) begin
            int e;
            e = find(ex_pc);
            if (e >= 0) begin
                if (ex_taken) begin
                    m_cnt[e] = (m_cnt[e] < 3) ? m_cnt[e] + 1 : 3;
                    m_tgt[e] = ex_target;
                end else begin
                    m_cnt[e] = (m_cnt[e] > 0) ? m_cnt[e] - 1 : 0;
                end
            end else if (ex_taken) begin
                m_valid[victim_index] = 1'b1;
                m_tag[victim_index]   = ex_pc[31:2];
                m_tgt[victim_index]   = ex_target;
                m_cnt[victim_index]   = 2;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int  h, e;
        logic exp_rep, exp_fresh;
        h = find(if_pc);
        e = find(ex_pc);
        exp_rep   = resetn && !flush_all && ex_valid && ex_taken && (e < 0);
        exp_fresh = resetn && !flush_all && id_valid && !id_stall && id_hit && !exp_rep;
        cmp("m_hit", 32'(hit), 32'(h >= 0));
        if (h >= 0) begin
            cmp("m_hit_index", 32'(hit_index), 32'(h));
            cmp("m_pred_taken", 32'(pred_taken), 32'(m_cnt[h] >= 2));
            cmp("m_pred_target", pred_target, m_tgt[h]);
        end else begin
            cmp("m_pred_taken", 32'(pred_taken), 32'd0);
            cmp("m_pred_target", pred_target, 32'd0);
        end
        cmp("m_replace_en", 32'(replace_en), 32'(exp_rep));
        cmp("m_fresh_en", 32'(fresh_en), 32'(exp_fresh));
        cmp("m_fresh_idx", 32'(fresh_line_index), 32'(id_hit_index));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic v, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tg, input logic [W-1:0] vic);
        ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg; victim_index = vic;
    endtask

    task automatic id_drive(input logic v, input logic st, input logic h, input logic [W-1:0] idx);
        id_valid = v; id_stall = st; id_hit = h; id_hit_index = idx;
    endtask

    logic [31:0] pool [24];

    initial begin
        // Reset state
        #2;
        if_pc = 32'h8000_0010;
        #1;
        cmp("rst_hit", 32'(hit), 32'd0);
        cmp("rst_pred_target", pred_target, 32'd0);
        cmp("rst_replace_en", 32'(replace_en), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        // Allocation on a taken miss, then lookup hit with counter 2
        ex_drive(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0100, 4'd3);
        #1;
        cmp("alloc_replace_en", 32'(replace_en), 32'd1);
        cmp("alloc_pre_hit", 32'(hit), 32'd0);
        cyc();
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        #1;
        cmp("alloc_hit", 32'(hit), 32'd1);
        cmp("alloc_hit_index", 32'(hit_index), 32'd3);
        cmp("alloc_pred_taken", 32'(pred_taken), 32'd1);
        cmp("alloc_pred_target", pred_target, 32'h8000_0100);

        // Two not-taken updates: counter 2 -> 1 -> 0, never allocates
        ex_drive(1'b1, 32'h8000_0010, 1'b0, 32'h0, 4'd9);
        #1;
        cmp("nt_replace_en", 32'(replace_en), 32'd0);
        cyc();
        cmp("nt1_pred_taken", 32'(pred_taken), 32'd0);
        cyc();
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        #1;
        cmp("nt2_pred_taken", 32'(pred_taken), 32'd0);
        cmp("nt2_hit_index", 32'(hit_index), 32'd3);

        // Allocation wins over refresh in the same cycle
        ex_drive(1'b1, 32'h8000_0200, 1'b1, 32'h8000_0300, 4'd5);
        id_drive(1'b1, 1'b0, 1'b1, 4'd2);
        #1;
        cmp("prio_replace_en", 32'(replace_en), 32'd1);
        cmp("prio_fresh_en", 32'(fresh_en), 32'd0);
        cyc();
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        id_drive(1'b0, 1'b0, 1'b0, '0);
        if_pc = 32'h8000_0200;
        #1;
        cmp("prio_hit", 32'(hit), 32'd1);
        cmp("prio_hit_index", 32'(hit_index), 32'd5);

        // Refresh gated by stall
        id_drive(1'b1, 1'b1, 1'b1, 4'd7);
        #1;
        cmp("stall_fresh_en", 32'(fresh_en), 32'd0);
        id_stall = 1'b0;
        #1;
        cmp("fresh_en", 32'(fresh_en), 32'd1);
        cmp("fresh_idx", 32'(fresh_line_index), 32'd7);
        cyc();

        // Fill all entries, then flush with a competing taken miss
        for (int i = 0; i < N; i++) begin
            ex_drive(1'b1, 32'h9000_0000 + 32'(i * 4), 1'b1, 32'h1000 + 32'(i), W'(i));
            cyc();
        end
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        if_pc = 32'h9000_0024;
        #1;
        cmp("fill_hit_index", 32'(hit_index), 32'd9);
        cmp("fill_pred_target", pred_target, 32'h0000_1009);
        flush_all = 1'b1;
        ex_drive(1'b1, 32'hA000_0000, 1'b1, 32'h2000, 4'd0);
        id_drive(1'b1, 1'b0, 1'b1, 4'd4);
        #1;
        cmp("flush_replace_en", 32'(replace_en), 32'd0);
        cmp("flush_fresh_en", 32'(fresh_en), 32'd0);
        cyc();
        flush_all = 1'b0;
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        id_drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i <= N; i++) begin
            if_pc = (i == N) ? 32'hA000_0000 : 32'h9000_0000 + 32'(i * 4);
            #0.1;
            cmp("flush_miss", 32'(hit), 32'd0);
        end
        cyc();

        // Reset pulse in the middle of a cycle with an allocation pending
        ex_drive(1'b1, 32'hB000_0000, 1'b1, 32'h3000, 4'd4);
        cyc();
        if_pc = 32'hB000_0000;
        ex_drive(1'b1, 32'hC000_0000, 1'b1, 32'h4000, 4'd6);
        id_drive(1'b1, 1'b0, 1'b1, 4'd4);
        #1;
        cmp("pre_rst_hit", 32'(hit), 32'd1);
        cmp("pre_rst_replace_en", 32'(replace_en), 32'd1);
        resetn = 1'b0;
        #1;
        cmp("mid_rst_hit", 32'(hit), 32'd0);
        cmp("mid_rst_pred_taken", 32'(pred_taken), 32'd0);
        cmp("mid_rst_pred_target", pred_target, 32'd0);
        cmp("mid_rst_replace_en", 32'(replace_en), 32'd0);
        cmp("mid_rst_fresh_en", 32'(fresh_en), 32'd0);
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        id_drive(1'b0, 1'b0, 1'b0, '0);
        #1;
        resetn = 1'b1;
        #1;
        cmp("post_rst_miss", 32'(hit), 32'd0);

        // First EX after reset release is honoured on the next edge
        ex_drive(1'b1, 32'hD000_0000, 1'b1, 32'h5000, 4'd1);
        if_pc = 32'hD000_0000;
        cyc();
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        #1;
        cmp("first_ex_hit", 32'(hit), 32'd1);
        cmp("first_ex_index", 32'(hit_index), 32'd1);

        // Randomised traffic checked by the model
        for (int i = 0; i < 24; i++) pool[i] = 32'h4000_0000 + 32'(i * 4) + 32'($urandom_range(0, 3));
        for (int n = 0; n < 3000; n++) begin
            if_pc     = ($urandom_range(0, 9) == 0) ? $urandom : pool[$urandom_range(0, 23)];
            ex_drive($urandom_range(0, 1) == 1, pool[$urandom_range(0, 23)],
                     $urandom_range(0, 2) != 0, $urandom, W'($urandom_range(0, N - 1)));
            id_drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 1, W'($urandom_range(0, N - 1)));
            flush_all = ($urandom_range(0, 59) == 0);
            cyc();
        end
        flush_all = 1'b0;
        ex_drive(1'b0, '0, 1'b0, '0, '0);
        id_drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
